// File: rtl/decode.sv
// LC3 decode stage: captures the fetched instruction and its PC, splits out the fields,
// reads the 8-entry register file and hands the result to execute over valid/ready.
module decode #(
  parameter int unsigned DATA_W    = 16,
  parameter bit          RF_BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              decode_start,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [DATA_W-1:0] npc_in,
  input  logic              exec_ready,
  input  logic              wb_en,
  input  logic [2:0]        wb_dr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              valid_out,
  output logic              busy,
  output logic [DATA_W-1:0] ir_out,
  output logic [DATA_W-1:0] npc_out,
  output logic [3:0]        opCode_out,
  output logic [2:0]        dr_out,
  output logic [2:0]        br_nzp_out,
  output logic [8:0]        offset_out,
  output logic              imm_sel_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [DATA_W-1:0] sr1_data_out,
  output logic [DATA_W-1:0] sr2_data_out,
  output logic [DATA_W-1:0] reg_out,
  output logic              illegal_out
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] npc_q, npc_d;
  logic [DATA_W-1:0] sr1_q, sr1_d;
  logic [DATA_W-1:0] sr2_q, sr2_d;
  logic [DATA_W-1:0] rf_q [8];
  logic [DATA_W-1:0] rf_d [8];
  logic              capture;
  logic [2:0]        sr1_idx, sr2_idx;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (decode_start) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (exec_ready) begin
          capture = decode_start;
          state_d = decode_start ? HOLD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rf_d = rf_q;
    if (wb_en) rf_d[wb_dr] = wb_data;
  end

  // Source indices come from the incoming word on capture and the held word otherwise,
  // so the same forwarding path serves both the capture read and the HOLD refresh.
  always_comb begin
    ir_d    = ir_q;
    npc_d   = npc_q;
    sr1_d   = sr1_q;
    sr2_d   = sr2_q;
    sr1_idx = ir_q[8:6];
    sr2_idx = ir_q[2:0];
    if (capture) begin
      ir_d    = instr_in;
      npc_d   = npc_in;
      sr1_idx = instr_in[8:6];
      sr2_idx = instr_in[2:0];
      sr1_d   = (RF_BYPASS && wb_en && wb_dr == sr1_idx) ? wb_data : rf_q[sr1_idx];
      sr2_d   = (RF_BYPASS && wb_en && wb_dr == sr2_idx) ? wb_data : rf_q[sr2_idx];
    end else if (state_q == HOLD && wb_en) begin
      if (wb_dr == sr1_idx) sr1_d = wb_data;
      if (wb_dr == sr2_idx) sr2_d = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ir_q    <= '0;
      npc_q   <= '0;
      sr1_q   <= '0;
      sr2_q   <= '0;
      for (int unsigned i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      npc_q   <= npc_d;
      sr1_q   <= sr1_d;
      sr2_q   <= sr2_d;
      rf_q    <= rf_d;
    end
  end

  assign valid_out    = (state_q == HOLD);
  assign busy         = (state_q == HOLD);
  assign ir_out       = ir_q;
  assign npc_out      = npc_q;
  assign opCode_out   = ir_q[15:12];
  assign dr_out       = ir_q[11:9];
  assign br_nzp_out   = ir_q[11:9];
  assign offset_out   = ir_q[8:0];
  assign imm_sel_out  = ir_q[5];
  assign imm_out      = {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]};
  assign sr1_data_out = sr1_q;
  assign sr2_data_out = sr2_q;
  assign reg_out      = sr1_q;
  assign illegal_out  = (ir_q[15:12] == 4'b1101);

endmodule

// File: tb/tb_decode.sv
// Directed bench for the decode stage: reset, capture, hold, bypass, back-to-back, illegal opcode.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst, decode_start, exec_ready, wb_en;
  logic [15:0] instr_in, npc_in, wb_data;
  logic [2:0]  wb_dr;
  logic        valid_out, busy, imm_sel_out, illegal_out;
  logic [15:0] ir_out, npc_out, imm_out, sr1_data_out, sr2_data_out, reg_out;
  logic [3:0]  opCode_out;
  logic [2:0]  dr_out, br_nzp_out;
  logic [8:0]  offset_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode #(.DATA_W(16), .RF_BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .decode_start(decode_start), .instr_in(instr_in),
    .npc_in(npc_in), .exec_ready(exec_ready), .wb_en(wb_en), .wb_dr(wb_dr),
    .wb_data(wb_data), .valid_out(valid_out), .busy(busy), .ir_out(ir_out),
    .npc_out(npc_out), .opCode_out(opCode_out), .dr_out(dr_out),
    .br_nzp_out(br_nzp_out), .offset_out(offset_out), .imm_sel_out(imm_sel_out),
    .imm_out(imm_out), .sr1_data_out(sr1_data_out), .sr2_data_out(sr2_data_out),
    .reg_out(reg_out), .illegal_out(illegal_out)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; decode_start = 1'b0; exec_ready = 1'b0; wb_en = 1'b0;
    instr_in = '0; npc_in = '0; wb_data = '0; wb_dr = '0;

    // 1: reset
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_valid", 16'(valid_out), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_ir", ir_out, 16'h0000);
    chk("rst_npc", npc_out, 16'h0000);
    chk("rst_sr1", sr1_data_out, 16'h0000);
    chk("rst_imm", imm_out, 16'h0000);

    // 2: write R2 then capture ADD R1,R2,R3
    wb_en = 1'b1; wb_dr = 3'd2; wb_data = 16'h0005;
    tick();
    wb_en = 1'b0;
    decode_start = 1'b1; instr_in = 16'h1283; npc_in = 16'h3001;
    tick();
    chk("add_valid", 16'(valid_out), 16'h1);
    chk("add_busy", 16'(busy), 16'h1);
    chk("add_op", 16'(opCode_out), 16'h1);
    chk("add_dr", 16'(dr_out), 16'h1);
    chk("add_sr1", sr1_data_out, 16'h0005);
    chk("add_sr2", sr2_data_out, 16'h0000);
    chk("add_npc", npc_out, 16'h3001);
    chk("add_imm_sel", 16'(imm_sel_out), 16'h0);
    chk("add_illegal", 16'(illegal_out), 16'h0);

    // 3: back-to-back into BRz #5, then stall 4 clks (R5 write-back, dropped start)
    exec_ready = 1'b1; decode_start = 1'b1; instr_in = 16'h0405; npc_in = 16'h3002;
    tick();
    chk("br_ir", ir_out, 16'h0405);
    exec_ready = 1'b0; decode_start = 1'b0;
    wb_en = 1'b1; wb_dr = 3'd5; wb_data = 16'h1234;
    tick();
    wb_en = 1'b0;
    chk("hold_sr2_refresh", sr2_data_out, 16'h1234);
    chk("hold_sr1_kept", sr1_data_out, 16'h0000);
    decode_start = 1'b1; instr_in = 16'hAAAA; npc_in = 16'h5555;
    tick();
    decode_start = 1'b0;
    chk("hold_drop_ir", ir_out, 16'h0405);
    chk("hold_drop_npc", npc_out, 16'h3002);
    repeat (2) begin
      tick();
      chk("hold_valid", 16'(valid_out), 16'h1);
      chk("hold_busy", 16'(busy), 16'h1);
      chk("br_nzp", 16'(br_nzp_out), 16'h0002);
      chk("br_offset", 16'(offset_out), 16'h0005);
    end
    exec_ready = 1'b1;
    tick();
    exec_ready = 1'b0;
    chk("release_valid", 16'(valid_out), 16'h0);
    chk("release_busy", 16'(busy), 16'h0);
    tick();
    chk("idle_keep_ir", ir_out, 16'h0405);
    chk("idle_valid", 16'(valid_out), 16'h0);

    // 4: same-cycle write-back of R6 and capture of JMP R6
    wb_en = 1'b1; wb_dr = 3'd6; wb_data = 16'hBEEF;
    decode_start = 1'b1; instr_in = 16'hC180; npc_in = 16'h3010;
    tick();
    wb_en = 1'b0;
    chk("jmp_reg_out", reg_out, 16'hBEEF);
    chk("jmp_op", 16'(opCode_out), 16'h000C);

    // 5: back-to-back with immediate ADD, then sr1==sr2 on R6
    exec_ready = 1'b1; decode_start = 1'b1; instr_in = 16'h127F; npc_in = 16'h3011;
    tick();
    chk("b2b_valid", 16'(valid_out), 16'h1);
    chk("b2b_imm", imm_out, 16'hFFFF);
    chk("b2b_imm_sel", 16'(imm_sel_out), 16'h1);
    chk("b2b_ir", ir_out, 16'h127F);
    instr_in = 16'h1D86; npc_in = 16'h3012;
    tick();
    exec_ready = 1'b0; decode_start = 1'b0;
    chk("same_sr1", sr1_data_out, 16'hBEEF);
    chk("same_sr2", sr2_data_out, 16'hBEEF);
    chk("pos_imm", imm_out, 16'h0006);

    // 6: reset while held, then R2 reads 0 and the reserved opcode flags illegal
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_valid", 16'(valid_out), 16'h0);
    chk("rst2_ir", ir_out, 16'h0000);
    decode_start = 1'b1; instr_in = 16'h1283; npc_in = 16'h4000;
    tick();
    chk("rst2_r2", sr1_data_out, 16'h0000);
    exec_ready = 1'b1; instr_in = 16'hD000; npc_in = 16'h4001;
    tick();
    exec_ready = 1'b0; decode_start = 1'b0;
    chk("ill_flag", 16'(illegal_out), 16'h1);
    chk("ill_valid", 16'(valid_out), 16'h1);
    tick();
    chk("ill_held", 16'(illegal_out), 16'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
